// File: rtl/parity_pkg.sv
// ============================================================================
// Module      : parity_pkg
// Description : Shared state encoding and parity-mode constants for the
//               parity block family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parity_pkg;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      CHECK = 2'd1,
      HOLD  = 2'd2
   } pf_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/parity_reduce.sv
// ============================================================================
// Module      : parity_reduce
// Description : Combinational XOR reduction of one word to a single bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_reduce #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data,
   output logic             parity
);

   assign parity = ^data;

endmodule

`default_nettype wire

// File: rtl/parity_frame_checker.sv
// ============================================================================
// Module      : parity_frame_checker
// Description : Streaming odd/even parity generator-checker for framed data
//               with a held result and a saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_frame_checker
   import parity_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 4,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode_odd,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_abort,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_parity,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int              c_CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(FRAME_LEN - 1);

   pf_state_t          r_state;
   pf_state_t          w_state_next;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_acc;
   logic               r_mode;
   logic               w_word_par;
   logic               w_p;
   logic               w_accept;
   logic               w_mismatch;

   parity_reduce #(
      .WIDTH (WIDTH)
   ) u_reduce (
      .data   (in_data),
      .parity (w_word_par)
   );

   assign in_ready   = (r_state != HOLD);
   assign w_accept   = in_valid & in_ready;
   assign w_p        = r_acc ^ (r_mode == PAR_ODD);
   assign w_mismatch = (in_data[0] != w_p);

   // Abort outranks a simultaneous beat; it is meaningless once a result is pending.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ACCUM: begin
            if (in_abort)
               w_state_next = ACCUM;
            else if (w_accept && (r_cnt == c_LAST))
               w_state_next = CHECK;
         end
         CHECK: begin
            if (in_abort)
               w_state_next = ACCUM;
            else if (w_accept)
               w_state_next = HOLD;
         end
         HOLD: begin
            if (out_valid && out_ready)
               w_state_next = ACCUM;
         end
         default: w_state_next = ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ACCUM;
         r_cnt      <= '0;
         r_acc      <= 1'b0;
         r_mode     <= PAR_EVEN;
         out_valid  <= 1'b0;
         out_parity <= 1'b0;
         out_err    <= 1'b0;
         err_count  <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            ACCUM: begin
               if (in_abort) begin
                  r_acc <= 1'b0;
                  r_cnt <= '0;
               end else if (w_accept) begin
                  r_acc <= r_acc ^ w_word_par;
                  if (r_cnt == '0)
                     r_mode <= mode_odd;
                  if (r_cnt == c_LAST)
                     r_cnt <= '0;
                  else
                     r_cnt <= r_cnt + c_CNT_W'(1);
               end
            end
            CHECK: begin
               if (in_abort) begin
                  r_acc <= 1'b0;
                  r_cnt <= '0;
               end else if (w_accept) begin
                  out_parity <= w_p;
                  out_err    <= w_mismatch;
                  out_valid  <= 1'b1;
                  r_acc      <= 1'b0;
                  if (w_mismatch && !(&err_count))
                     err_count <= err_count + ERR_CNT_W'(1);
               end
            end
            HOLD: begin
               if (out_valid && out_ready)
                  out_valid <= 1'b0;
            end
            default: begin
               r_cnt <= '0;
               r_acc <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_parity_frame_checker.sv
// ============================================================================
// Module      : tb_parity_frame_checker
// Description : Directed self-checking bench for parity_frame_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_frame_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode_odd = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       in_abort = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       out_parity;
   logic       out_err;
   logic [7:0] err_count;

   int n_chk  = 0;
   int n_pass = 0;

   parity_frame_checker #(
      .WIDTH     (8),
      .FRAME_LEN (4),
      .ERR_CNT_W (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mode_odd   (mode_odd),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_abort   (in_abort),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_parity (out_parity),
      .out_err    (out_err),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic beat(input logic [7:0] d);
      int w;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      w = 0;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic frame(input logic m, input logic [7:0] d0, d1, d2, d3, c);
      mode_odd = m;
      beat(d0); beat(d1); beat(d2); beat(d3); beat(c);
   endtask

   task automatic result(input string tag, input logic par, err, input logic [7:0] cnt);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_parity"}, 32'(out_parity), 32'(par));
      chk({tag, "_err"}, 32'(out_err), 32'(err));
      chk({tag, "_count"}, 32'(err_count), 32'(cnt));
   endtask

   task automatic consume(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_parity", 32'(out_parity), 32'd0);
      chk("rst_err", 32'(out_err), 32'd0);
      chk("rst_count", 32'(err_count), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);

      // 1: odd mode, one set bit, expected 0
      frame(1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
      result("t1", 1'b0, 1'b0, 8'd0);
      consume("t1");

      // 2 + 3: error frame held for five cycles with a beat and abort offered
      frame(1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01);
      result("t2", 1'b0, 1'b1, 8'd1);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      in_abort = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_ready", 32'(in_ready), 32'd0);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_err", 32'(out_err), 32'd1);
         chk("hold_parity", 32'(out_parity), 32'd0);
         chk("hold_count", 32'(err_count), 32'd1);
      end
      in_valid = 1'b0;
      in_abort = 1'b0;
      consume("t3");

      frame(1'b0, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00);
      result("t2e", 1'b0, 1'b0, 8'd1);
      consume("t2e");

      // odd mode, all zeros -> parity bit 1
      frame(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
      result("odd0", 1'b1, 1'b0, 8'd1);
      consume("odd0");

      // mode_odd changing after the first beat must not matter
      mode_odd = 1'b0;
      beat(8'h00);
      mode_odd = 1'b1;
      beat(8'h00); beat(8'h00); beat(8'h00); beat(8'h00);
      result("modechg", 1'b0, 1'b0, 8'd1);
      consume("modechg");

      // 4: abort after two beats, abort beat is not consumed
      mode_odd = 1'b1;
      beat(8'h12);
      beat(8'h34);
      @(negedge clk);
      in_valid = 1'b1;
      in_abort = 1'b1;
      in_data  = 8'h01;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_abort = 1'b0;
      frame(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00);
      result("abort", 1'b0, 1'b0, 8'd1);
      consume("abort");

      // 5: saturate the error counter
      for (int i = 0; i < 300; i++) begin
         frame(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
         if (i == 9) chk("sat_mid", 32'(err_count), 32'd11);
         if (i == 253) chk("sat_hit", 32'(err_count), 32'd255);
         consume("sat");
      end
      chk("sat_end", 32'(err_count), 32'd255);

      // 6: reset while a result is pending
      frame(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_valid", 32'(out_valid), 32'd0);
      chk("async_count", 32'(err_count), 32'd0);
      chk("async_err", 32'(out_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      frame(1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
      result("post_rst", 1'b0, 1'b0, 8'd0);
      consume("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
